// File: rtl/imm_pkg.sv
// Shared definitions for the LC-3 immediate narrowing pipeline: field kinds,
// per-kind field widths and signedness.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM5  = 3'd0,
    OFF6  = 3'd1,
    OFF9  = 3'd2,
    OFF11 = 3'd3,
    TRAP8 = 3'd4
  } kind_e;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FIELD_W = 11;

  localparam logic [3:0] W_IMM5  = 4'd5;
  localparam logic [3:0] W_OFF6  = 4'd6;
  localparam logic [3:0] W_OFF9  = 4'd9;
  localparam logic [3:0] W_OFF11 = 4'd11;
  localparam logic [3:0] W_TRAP8 = 4'd8;

  // Bit k set when kind k is a two's-complement field.
  localparam logic [4:0] KIND_SIGNED = 5'b01111;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit test: truncates a 16-bit value to the selected instruction
// field and reports whether extending the field back reproduces the value.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0]  value_i,
  input  logic [2:0]         kind_i,
  output logic [FIELD_W-1:0] field_o,
  output logic               fits_o
);

  logic [3:0]               w;
  logic                     sgn;
  logic                     known;
  logic signed [DATA_W-1:0] shifted;
  logic [FIELD_W-1:0]       mask;

  always_comb begin
    w     = 4'd0;
    sgn   = 1'b0;
    known = 1'b1;
    case (kind_i)
      IMM5:    begin w = W_IMM5;  sgn = KIND_SIGNED[IMM5];  end
      OFF6:    begin w = W_OFF6;  sgn = KIND_SIGNED[OFF6];  end
      OFF9:    begin w = W_OFF9;  sgn = KIND_SIGNED[OFF9];  end
      OFF11:   begin w = W_OFF11; sgn = KIND_SIGNED[OFF11]; end
      TRAP8:   begin w = W_TRAP8; sgn = KIND_SIGNED[TRAP8]; end
      default: known = 1'b0;
    endcase
  end

  // A signed value fits when everything from the field's sign bit upward is
  // a pure sign extension, i.e. the arithmetic shift leaves 0 or -1.
  always_comb begin
    shifted = $signed(value_i) >>> (w - 4'd1);
    mask    = (11'd1 << w) - 11'd1;
    field_o = '0;
    fits_o  = 1'b0;
    if (known) begin
      field_o = value_i[FIELD_W-1:0] & mask;
      fits_o  = sgn ? ((shifted == '0) || (shifted == '1))
                    : (value_i[DATA_W-1:8] == 8'h00);
    end
  end

endmodule

// File: rtl/imm_narrow.sv
// Two-stage valid/ready narrowing encoder for LC-3 instruction fields.
// Define IMM_NARROW_STATS_EN to build the saturating overflow counter.
module imm_narrow
  import imm_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_value,
  input  logic [2:0]         in_kind,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic               out_fits,
  output logic [2:0]         out_kind,
  output logic [15:0]        ovf_count
);

  logic               vld_p1_q, vld_p2_q;
  logic [DATA_W-1:0]  value_p1_q;
  logic [2:0]         kind_p1_q, kind_p2_q;
  logic [FIELD_W-1:0] field_p1, field_p2_q;
  logic               fits_p1, fits_p2_q;
  logic               adv_p2;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (adv_p2)   vld_p2_q <= vld_p1_q;
    end
  end

  // Stage 1: capture the raw request
  always_ff @(posedge Clk) begin
    if (in_valid && in_ready) begin
      value_p1_q <= in_value;
      kind_p1_q  <= in_kind;
    end
  end

  imm_fit_check u_fit (
    .value_i (value_p1_q),
    .kind_i  (kind_p1_q),
    .field_o (field_p1),
    .fits_o  (fits_p1)
  );

  // Stage 2: register the narrowed result
  always_ff @(posedge Clk) begin
    if (Reset) begin
      field_p2_q <= '0;
      fits_p2_q  <= 1'b0;
      kind_p2_q  <= 3'd0;
    end else if (adv_p2 && vld_p1_q) begin
      field_p2_q <= field_p1;
      fits_p2_q  <= fits_p1;
      kind_p2_q  <= kind_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_field = field_p2_q;
  assign out_fits  = fits_p2_q;
  assign out_kind  = kind_p2_q;

`ifdef IMM_NARROW_STATS_EN
  logic [15:0] ovf_q, ovf_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    ovf_d = ovf_q;
    if (out_valid && out_ready && !out_fits) ovf_d = sat_inc(ovf_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_narrow.sv
// Scoreboard bench for imm_narrow: a driver pushes model results on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_imm_narrow;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic [2:0]  in_kind = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_field;
  logic        out_fits;
  logic [2:0]  out_kind;
  logic [15:0] ovf_count;

  imm_narrow dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_kind(in_kind),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_fits(out_fits), .out_kind(out_kind), .ovf_count(ovf_count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [10:0] f; logic fits; logic [2:0] k; } exp_t;
  exp_t sb[$];

  int n_pass = 0, n_tot = 0;
  int ncyc = 0;
  int acc_ncyc = 0;
  int bp_mode = 0;     // 0: out_ready high, 1: random backpressure
  int hold_cnt = 0;    // forces out_ready low for this many cycles
  int ovf_model = 0;
  bit lat_arm = 0, lat_seen = 0, lat_done = 0;
  int first_ov = 0, run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Reference: representable range per kind, computed with integer arithmetic.
  function automatic exp_t ref_model(input logic [15:0] v, input logic [2:0] k);
    exp_t e;
    int n, sv;
    bit sgn;
    n = 0; sgn = 1;
    case (k)
      3'd0: n = 5;
      3'd1: n = 6;
      3'd2: n = 9;
      3'd3: n = 11;
      3'd4: begin n = 8; sgn = 0; end
      default: n = 0;
    endcase
    e.k = k;
    if (n == 0) begin
      e.f = '0; e.fits = 1'b0;
    end else begin
      e.f = 11'(int'(v) % (1 << n));
      sv = int'($signed(v));
      if (sgn) e.fits = (sv >= -(1 << (n - 1))) && (sv < (1 << (n - 1)));
      else     e.fits = int'(v) < 256;
    end
    return e;
  endfunction

  always @(posedge Clk) ncyc <= ncyc + 1;

  always @(posedge Clk) begin
    #1;
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  task automatic send(input logic [15:0] v, input logic [2:0] k);
    bit acc;
    in_valid = 1'b1; in_value = v; in_kind = k;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      acc = in_ready;
      if (acc) acc_ncyc = ncyc;
      @(posedge Clk);
      if (acc) begin
        sb.push_back(ref_model(v, k));
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge Clk);
    check("drain_empty", sb.size(), 0);
    @(posedge Clk); #1;
  endtask

  // Monitor
  bit          stall_v = 0;
  logic [10:0] h_f;
  logic        h_fits;
  logic [2:0]  h_k;

  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      stall_v = 0;
    end else begin
      check("in_ready", in_ready, (sb.size() < 2) || out_ready);
      check("ovf_count", ovf_count, ovf_model);
      if (stall_v) begin
        check("stall_field", out_field, h_f);
        check("stall_fits", out_fits, h_fits);
        check("stall_kind", out_kind, h_k);
      end
      if (out_valid) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else if (out_ready) begin
          e = sb.pop_front();
          check("field", out_field, e.f);
          check("fits", out_fits, e.fits);
          check("kind", out_kind, e.k);
`ifdef IMM_NARROW_STATS_EN
          if (!e.fits && ovf_model < 65535) ovf_model++;
`endif
        end
      end
      stall_v = out_valid && !out_ready;
      h_f = out_field; h_fits = out_fits; h_k = out_kind;
      if (lat_arm && !lat_done) begin
        if (out_valid && !lat_seen) begin lat_seen = 1; first_ov = ncyc; end
        if (lat_seen) begin
          if (out_valid) run_len++;
          else lat_done = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_field", out_field, 0);
    check("rst_out_fits", out_fits, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge Clk); #1;

    // Boundary vectors
    send(16'h000F, 3'd0); send(16'hFFF0, 3'd0); send(16'h0010, 3'd0); send(16'hFFEF, 3'd0);
    send(16'h001F, 3'd1); send(16'hFFE0, 3'd1); send(16'h0020, 3'd1);
    send(16'h00FF, 3'd2); send(16'hFF00, 3'd2); send(16'h0100, 3'd2);
    send(16'h03FF, 3'd3); send(16'hFC00, 3'd3); send(16'h0400, 3'd3); send(16'hFBFF, 3'd3);
    send(16'h00FF, 3'd4); send(16'h0100, 3'd4); send(16'hFFFF, 3'd4); send(16'h0000, 3'd4);
    send(16'h1234, 3'd5); send(16'h0001, 3'd6); send(16'hFFFF, 3'd7);
    drain();

    // Latency / throughput
    lat_arm = 1;
    for (int i = 0; i < 10; i++) begin
      send(16'(i * 7), 3'(i % 5));
      if (i == 0) first_ov = -1;
      if (i == 0) run_len = 0;
      if (i == 0) v = 16'(acc_ncyc);
    end
    drain();
    repeat (2) @(posedge Clk);
    check("latency", first_ov - int'(v), 2);
    check("throughput_run", run_len, 10);
    lat_arm = 0;
    #1;

    // Backpressure mid-stream
    for (int i = 0; i < 8; i++) begin
      if (i == 3) hold_cnt = 5;
      send(16'hFFF0 + 16'(i * 3), 3'(i % 5));
    end
    drain();

    // Randomized with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: v = 16'($urandom);
        1: v = 16'($signed(10'($urandom)));
        default: v = 16'($urandom_range(0, 300));
      endcase
      send(v, 3'($urandom_range(0, 7)));
    end
    bp_mode = 0;
    drain();

    // Reset with both stages full
    hold_cnt = 50;
    send(16'h0400, 3'd3);
    send(16'h0010, 3'd0);
    @(negedge Clk);
    check("full_in_ready", in_ready, 0);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    sb.delete();
    ovf_model = 0;
    hold_cnt = 0;
    @(negedge Clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_ovf", ovf_count, 0);
    repeat (5) @(posedge Clk);
    #1;
    send(16'h0005, 3'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
